// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared encodings for the mul/div sequencing controller
package multdiv_pkg;
  localparam logic [4:0] OPC_ALU = 5'b00000;
  localparam logic [4:0] ALUOP_MUL = 5'b00110;
  localparam logic [4:0] ALUOP_DIV = 5'b00111;
  localparam logic [31:0] EXC_MUL = 32'd1;
  localparam logic [31:0] EXC_DIV = 32'd2;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/md_decode.sv
// md_decode: flags a mul/div in the DX latch; also used by the bypass logic
module md_decode
  import multdiv_pkg::*;
(
  input  logic [31:0] dx_insn,
  output logic        is_md,
  output logic        is_div
);
  logic w_unused;
  assign w_unused = ^{dx_insn[26:7], dx_insn[1:0]};
  assign is_md = (dx_insn[31:27] == OPC_ALU) && (dx_insn[6:2] == ALUOP_MUL || dx_insn[6:2] == ALUOP_DIV);
  assign is_div = dx_insn[2];
endmodule

// File: rtl/multdiv_sched.sv
// multdiv_sched: issues the multdiv start pulse, stalls until result or
// watchdog, then presents the result for one advancing cycle.
module multdiv_sched
  import multdiv_pkg::*;
#(
  parameter int TIMEOUT = 40,
  parameter int CNT_W = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dx_insn,
  input  logic        flush,
  input  logic        pipe_hold,
  input  logic        md_result_rdy,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall,
  output logic        md_done,
  output logic [31:0] result_out,
  output logic        exception_out,
  output logic [31:0] exc_code,
  output logic        timeout
);
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic r_op_is_div, r_exc, r_timeout;
  logic [31:0] r_result;
  logic w_is_md, w_is_div, w_start, w_expire;
  md_decode u_dec (.dx_insn(dx_insn), .is_md(w_is_md), .is_div(w_is_div));
  always_comb begin
    w_next = r_state;
    w_start = r_state == IDLE && w_is_md && !flush && !reset;
    w_expire = r_state == BUSY && !md_result_rdy && r_cnt == CNT_W'(TIMEOUT - 1);
    case (r_state)
      IDLE: w_next = w_start ? BUSY : IDLE;
      BUSY: w_next = (md_result_rdy || w_expire) ? DONE : BUSY;
      DONE: w_next = pipe_hold ? DONE : IDLE;
      default: w_next = IDLE;
    endcase
    ctrl_mult = w_start && !w_is_div;
    ctrl_div = w_start && w_is_div;
    stall = w_start || r_state == BUSY || (r_state == DONE && pipe_hold);
    md_done = r_state == DONE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_op_is_div <= 1'b0;
      r_result <= '0;
      r_exc <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_op_is_div <= w_is_div;
        r_cnt <= '0;
      end
      if (r_state == BUSY) begin
        r_cnt <= r_cnt + CNT_W'(1);
        // a result arriving on the expiry cycle takes priority over the watchdog
        if (md_result_rdy) begin
          r_result <= md_result;
          r_exc <= md_exception;
        end else if (w_expire) begin
          r_result <= '0;
          r_exc <= 1'b1;
          r_timeout <= 1'b1;
        end
      end
    end
  end
  assign result_out = r_result;
  assign exception_out = r_exc;
  assign timeout = r_timeout;
  assign exc_code = r_exc ? (r_op_is_div ? EXC_DIV : EXC_MUL) : 32'd0;
endmodule

// File: tb/tb_multdiv_sched.sv
// tb_multdiv_sched: transaction-level model check plus directed literal checks
module tb_multdiv_sched;
  localparam int TIMEOUT = 40;
  logic clock = 1'b0;
  logic reset, flush, pipe_hold, md_result_rdy, md_exception;
  logic [31:0] dx_insn, md_result;
  logic ctrl_mult, ctrl_div, stall, md_done, exception_out, timeout;
  logic [31:0] result_out, exc_code;
  always #5 clock = ~clock;
  multdiv_sched #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .dx_insn(dx_insn), .flush(flush), .pipe_hold(pipe_hold),
    .md_result_rdy(md_result_rdy), .md_exception(md_exception), .md_result(md_result),
    .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .stall(stall), .md_done(md_done),
    .result_out(result_out), .exception_out(exception_out), .exc_code(exc_code), .timeout(timeout)
  );
  int n_chk = 0, n_pass = 0;
  bit m_active = 0, m_ready = 0, m_div = 0, m_exc = 0, m_to = 0;
  int m_elapsed = 0;
  logic [31:0] m_res = 0;
  logic s_cm, s_cd, s_stall, s_done, s_exc, s_to;
  logic [31:0] s_res, s_code;
  bit prev_ctrl = 0;
  int cnt_stall, cnt_done, cnt_ctrl;
  localparam logic [31:0] NOP = 32'h0;
  function automatic logic [31:0] mk(input logic [4:0] aluop);
    logic [31:0] w;
    w = $urandom;
    w[31:27] = 5'b00000;
    w[6:2] = aluop;
    return w;
  endfunction
  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask
  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask
  task automatic drv(input logic [31:0] insn, input logic fl, input logic ph, input logic rdy,
                     input logic ex, input logic [31:0] res);
    dx_insn = insn; flush = fl; pipe_hold = ph; md_result_rdy = rdy; md_exception = ex; md_result = res;
  endtask
  // one clock: compare outputs against the model, then advance the model at the edge
  task automatic cyc();
    bit md, start, is_div;
    #1;
    md = dx_insn[31:27] == 5'd0 && (dx_insn[6:2] == 5'd6 || dx_insn[6:2] == 5'd7);
    is_div = dx_insn[6:2] == 5'd7;
    start = !m_active && !m_ready && md && !flush && !reset;
    chk1("ctrl_mult", ctrl_mult, start && !is_div);
    chk1("ctrl_div", ctrl_div, start && is_div);
    chk1("stall", stall, start || m_active || (m_ready && pipe_hold));
    chk1("md_done", md_done, m_ready);
    chk32("result_out", result_out, m_res);
    chk1("exception_out", exception_out, m_exc);
    chk32("exc_code", exc_code, m_exc ? (m_div ? 32'd2 : 32'd1) : 32'd0);
    chk1("timeout", timeout, m_to);
    chk1("ctrl_back_to_back", prev_ctrl && (ctrl_mult || ctrl_div), 1'b0);
    s_cm = ctrl_mult; s_cd = ctrl_div; s_stall = stall; s_done = md_done;
    s_res = result_out; s_code = exc_code; s_exc = exception_out; s_to = timeout;
    cnt_stall += int'(stall); cnt_done += int'(md_done); cnt_ctrl += int'(ctrl_mult || ctrl_div);
    prev_ctrl = ctrl_mult || ctrl_div;
    @(posedge clock);
    if (reset) begin
      m_active = 0; m_ready = 0; m_div = 0; m_exc = 0; m_to = 0; m_res = 0; m_elapsed = 0;
    end else if (start) begin
      m_active = 1; m_elapsed = 0; m_div = is_div;
    end else if (m_active) begin
      if (md_result_rdy) begin
        m_res = md_result; m_exc = md_exception; m_active = 0; m_ready = 1;
      end else if (m_elapsed == TIMEOUT - 1) begin
        m_res = 0; m_exc = 1; m_to = 1; m_active = 0; m_ready = 1;
      end else m_elapsed++;
    end else if (m_ready && !pipe_hold) m_ready = 0;
    @(negedge clock);
  endtask
  task automatic clr();
    cnt_stall = 0; cnt_done = 0; cnt_ctrl = 0;
  endtask
  initial begin
    logic [31:0] ins;
    reset = 1;
    drv(NOP, 0, 0, 0, 0, 0);
    @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    cyc();
    reset = 0;
    chk1("reset_stall", s_stall, 1'b0);
    chk1("reset_done", s_done, 1'b0);
    chk32("reset_result", s_res, 32'h0);
    chk1("reset_timeout", s_to, 1'b0);
    // mul with result after 32 cycles
    clr();
    ins = mk(5'b00110);
    drv(ins, 0, 0, 0, 0, 0);
    cyc();
    chk1("t1_ctrl_mult", s_cm, 1'b1);
    for (int i = 1; i < 32; i++) cyc();
    drv(ins, 0, 0, 1, 0, 32'h0000_0F00);
    cyc();
    chk32("t1_stall_cycles", 32'(cnt_stall), 32'd33);
    drv(ins, 0, 0, 0, 0, 32'hFFFF_FFFF);
    cyc();
    chk1("t1_done", s_done, 1'b1);
    chk32("t1_result", s_res, 32'h0000_0F00);
    chk32("t1_exc_code", s_code, 32'd0);
    drv(NOP, 0, 0, 0, 0, 0);
    cyc();
    chk1("t1_done_after", s_done, 1'b0);
    chk32("t1_result_kept", s_res, 32'h0000_0F00);
    chk32("t1_ctrl_count", 32'(cnt_ctrl), 32'd1);
    // div with exception after 5 cycles
    ins = mk(5'b00111);
    drv(ins, 0, 0, 0, 0, 0);
    cyc();
    chk1("t2_ctrl_div", s_cd, 1'b1);
    for (int i = 1; i < 5; i++) cyc();
    drv(ins, 0, 0, 1, 1, 32'h1111_2222);
    cyc();
    drv(ins, 0, 0, 0, 0, 0);
    cyc();
    chk1("t2_exception", s_exc, 1'b1);
    chk32("t2_exc_code", s_code, 32'd2);
    chk1("t2_timeout", s_to, 1'b0);
    drv(NOP, 0, 0, 0, 0, 0);
    cyc();
    // flushed mul
    clr();
    drv(mk(5'b00110), 1, 0, 0, 0, 0);
    cyc();
    chk1("t3_no_pulse", s_cm, 1'b0);
    chk1("t3_no_stall", s_stall, 1'b0);
    drv(NOP, 0, 0, 1, 0, 32'h5);
    cyc();
    chk32("t3_stall_count", 32'(cnt_stall + cnt_done), 32'd0);
    // div that never completes
    clr();
    ins = mk(5'b00111);
    drv(ins, 0, 0, 0, 0, 0);
    cyc();
    cnt_stall = 0;
    for (int i = 1; i <= TIMEOUT; i++) cyc();
    chk32("t4_busy_stall_cycles", 32'(cnt_stall), 32'd40);
    cyc();
    chk1("t4_done", s_done, 1'b1);
    chk1("t4_exception", s_exc, 1'b1);
    chk32("t4_exc_code", s_code, 32'd2);
    chk1("t4_timeout", s_to, 1'b1);
    chk32("t4_result", s_res, 32'h0);
    drv(NOP, 0, 0, 0, 0, 0);
    cyc();
    // pipe_hold in DONE for 3 cycles
    clr();
    ins = mk(5'b00110);
    drv(ins, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc();
    drv(ins, 0, 0, 1, 0, 32'h1234);
    cyc();
    drv(ins, 0, 1, 0, 0, 32'h9999);
    for (int i = 0; i < 3; i++) cyc();
    chk1("t5_hold_stall", s_stall, 1'b1);
    drv(ins, 0, 0, 0, 0, 32'h9999);
    cyc();
    chk32("t5_result_stable", s_res, 32'h1234);
    drv(NOP, 0, 0, 0, 0, 0);
    cyc();
    chk32("t5_done_cycles", 32'(cnt_done), 32'd4);
    chk32("t5_ctrl_count", 32'(cnt_ctrl), 32'd1);
    chk1("t5_timeout_sticky", s_to, 1'b1);
    // reset during BUSY cycle 10
    ins = mk(5'b00110);
    drv(ins, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc();
    reset = 1;
    cyc();
    reset = 0;
    drv(NOP, 0, 0, 0, 0, 0);
    cyc();
    chk1("t6_stall", s_stall, 1'b0);
    chk1("t6_done", s_done, 1'b0);
    drv(NOP, 0, 0, 1, 0, 32'hDEAD);
    cyc();
    drv(NOP, 0, 0, 0, 0, 0);
    cyc();
    chk1("t6_late_rdy_ignored", s_done, 1'b0);
    chk1("t6_timeout_cleared", s_to, 1'b0);
    ins = mk(5'b00110);
    drv(ins, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    drv(ins, 0, 0, 1, 0, 32'h77);
    cyc();
    drv(ins, 0, 0, 0, 0, 0);
    cyc();
    chk32("t6_restart_result", s_res, 32'h77);
    drv(NOP, 0, 0, 0, 0, 0);
    cyc();
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom % 400) == 0;
      if (!s_stall) begin
        case ($urandom % 4)
          0: dx_insn = mk(5'b00110);
          1: dx_insn = mk(5'b00111);
          2: dx_insn = $urandom;
          default: dx_insn = mk(5'($urandom));
        endcase
        flush = ($urandom % 6) == 0;
      end else flush = 0;
      pipe_hold = ($urandom % 3) == 0;
      md_result_rdy = ($urandom % 14) == 0;
      md_exception = 1'($urandom);
      md_result = $urandom;
      cyc();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/multdiv_sched.md
Name: multdiv_sched

Overview:
Controller that sequences the multi-cycle multiplier/divider for the 5-stage pipeline. It detects a mul/div in the DX latch, issues a one-cycle start pulse to the multdiv unit, and stalls the pipeline until the result is ready or a watchdog expires. It then presents the result and exception status to the X/M boundary for exactly one advancing cycle. It sits alongside the data-hazard stall logic; the two stall sources are ORed outside this block.

Parameters:
TIMEOUT, 40, maximum BUSY cycles before a forced exception completion (must be >= 2)
CNT_W, 6, cycle counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clock  input  1  pipeline clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state on the next rising edge
dx_insn  input  32  instruction in DX latch: opcode [31:27], rd [26:22], aluop [6:2]
flush  input  1  DX is being squashed this cycle (taken branch/jump)
pipe_hold  input  1  downstream cannot accept a completed result this cycle
md_result_rdy  input  1  multdiv result valid (level, sampled only in BUSY)
md_exception  input  1  multdiv overflow / divide-by-zero, valid with md_result_rdy
md_result  input  32  multdiv result, valid with md_result_rdy
ctrl_mult  output  1  one-cycle start pulse, multiply
ctrl_div  output  1  one-cycle start pulse, divide
stall  output  1  freeze PC, FD and DX latches
md_done  output  1  result_out/exception_out valid; DX may advance
result_out  output  32  captured multdiv result
exception_out  output  1  captured exception (including timeout)
exc_code  output  32  rstatus value: 1 = mul exception, 2 = div exception, 0 = none
timeout  output  1  sticky flag: watchdog expired since reset

Behaviour:
- Decode: is_md = (opcode == 5'b00000) && (aluop == 5'b00110 mul || aluop == 5'b00111 div). is_div = aluop[0].
- States: IDLE, BUSY, DONE. Reset -> IDLE, counter 0, op_is_div 0, all registered outputs 0, timeout 0.
- IDLE:
  - If is_md && !flush: ctrl_mult/ctrl_div asserts combinationally this cycle, per is_div.
  - Same cycle: stall=1, latch op_is_div, counter<=0, next state BUSY.
  - Otherwise: stall=0, ctrl_*=0, and the block stays in IDLE.
  - md_result_rdy is ignored in IDLE.
- BUSY:
  - stall=1, ctrl_*=0, counter increments every cycle.
  - On md_result_rdy: capture md_result into result_out and md_exception into exception_out, then go to DONE.
  - If md_result_rdy is low and the counter is TIMEOUT-1: result_out<=0, exception_out<=1, timeout<=1, go to DONE.
  - If md_result_rdy is high in the same cycle as the timeout: the result wins and the timeout does not fire.
  - flush is ignored in BUSY; the stall freezes everything younger, so a flush here comes from an external source and is a bench error.
- DONE:
  - stall=0, md_done=1. result_out, exception_out and exc_code are held stable.
  - exc_code = exception_out ? (op_is_div ? 2 : 1) : 0.
  - If pipe_hold: stay in DONE with stall=1 and md_done=1.
  - Otherwise: go to IDLE; DX advances this edge, so the same instruction cannot retrigger.
  - In the first IDLE cycle after DONE, md_done=0. result_out keeps its value until the next capture.
- Back-to-back mul/div: the second instruction enters DX when DONE exits and starts in the following IDLE cycle. Minimum spacing between start pulses is therefore 3 cycles.
- Reset in BUSY or DONE: IDLE on the next edge, with no ctrl pulse that cycle. The multdiv unit is reset by the same signal.
- Exactly one of ctrl_mult/ctrl_div is high at a time, and never in two consecutive cycles.

Decomposition:
- Package multdiv_pkg holds:
  - OPC_ALU = 5'b00000, ALUOP_MUL = 5'b00110, ALUOP_DIV = 5'b00111.
  - EXC_MUL = 32'd1, EXC_DIV = 32'd2.
  - State encodings IDLE/BUSY/DONE.
- Sub-module md_decode (combinational): dx_insn -> is_md, is_div. It is reused by the bypass logic to block forwarding from a stalled mul/div.

Test Plan:
- mul (opcode 0, aluop 00110) in DX; md_result_rdy after 32 cycles with result 0x0000_0F00:
  - ctrl_mult high in cycle 0 only; stall high cycles 0-32.
  - md_done high in cycle 33 with result_out=0x0000_0F00 and exc_code=0.
- div, then md_result_rdy with md_exception=1 after 5 cycles -> exception_out=1, exc_code=2, timeout=0.
- mul in DX with flush=1 in the same cycle -> no ctrl pulse, stall stays 0, state stays IDLE.
- div and md_result_rdy never arrives (TIMEOUT=40) -> stall for 40 cycles, then md_done with exception_out=1, exc_code=2, timeout=1 (sticky).
- pipe_hold=1 for 3 cycles in DONE -> md_done held 3+1 cycles with result_out stable; no second ctrl pulse.
- reset asserted in BUSY cycle 10 -> next cycle stall=0 and md_done=0; md_result_rdy a cycle later is ignored. A following mul starts normally with a fresh counter.
